// File: rtl/sop_minterm_extractor.sv
// rtl/sop_minterm_extractor.sv - exhaustive truth-table sweep of a small combinational gate
// Drives every input vector, samples DUT_F after SETTLE extra cycles, and builds mask/count/compare.
module sop_minterm_extractor #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      DUT_IN,
  input  logic                 DUT_F,
  input  logic [2**N_IN-1:0]   EXPECT,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   MINTERMS,
  output logic [N_IN:0]        COUNT,
  output logic                 MATCH
);

  localparam int NV = 2**N_IN;
  localparam int WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WW-1:0]   SETTLE_W = WW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [N_IN-1:0]  r_vec;
  logic [WW-1:0]    r_wait;
  logic [NV-1:0]    r_minterms;
  logic [N_IN:0]    r_count;
  logic             r_match;
  logic             w_sample;
  logic             w_last;
  logic [NV-1:0]    w_minterms_next;

  // Mask is cleared at start, so OR-ing in the sampled bit is the same as a bit write.
  always_comb begin
    w_sample        = (r_state == S_RUN) && (r_wait == SETTLE_W);
    w_last          = w_sample && (r_vec == LAST_VEC);
    w_minterms_next = r_minterms | (NV'(DUT_F) << r_vec);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec      <= '0;
      r_wait     <= '0;
      r_minterms <= '0;
      r_count    <= '0;
      r_match    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec      <= '0;
            r_wait     <= '0;
            r_minterms <= '0;
            r_count    <= '0;
            r_match    <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_sample) begin
            r_wait     <= '0;
            r_minterms <= w_minterms_next;
            r_count    <= r_count + (N_IN+1)'(DUT_F);
            // The vector register doubles as DUT_IN, so it returns to 0 on the final sample.
            if (w_last) begin
              r_vec   <= '0;
              r_match <= (w_minterms_next == EXPECT);
            end else begin
              r_vec <= r_vec + 1'b1;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign DUT_IN   = r_vec;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign MINTERMS = r_minterms;
  assign COUNT    = r_count;
  assign MATCH    = r_match;

endmodule
